bcd_disp_mux: RTL



---
 rtl/bcd_disp_pkg.sv | 36 +++
 rtl/bcd_to_sseg.sv | 27 ++
 rtl/bcd_disp_mux.sv | 103 ++++++++++
 3 files changed

// File: rtl/bcd_disp_pkg.sv
// Shared constants and types for the four-digit seven-segment scan driver.
// Segment patterns are active-low {g,f,e,d,c,b,a}; anodes are active-low.
package bcd_disp_pkg;

  localparam logic [6:0] SEG_0    = 7'b1000000;
  localparam logic [6:0] SEG_1    = 7'b1111001;
  localparam logic [6:0] SEG_2    = 7'b0100100;
  localparam logic [6:0] SEG_3    = 7'b0110000;
  localparam logic [6:0] SEG_4    = 7'b0011001;
  localparam logic [6:0] SEG_5    = 7'b0010010;
  localparam logic [6:0] SEG_6    = 7'b0000010;
  localparam logic [6:0] SEG_7    = 7'b1111000;
  localparam logic [6:0] SEG_8    = 7'b0000000;
  localparam logic [6:0] SEG_9    = 7'b0010000;
  localparam logic [6:0] SEG_DASH = 7'b0111111;

  localparam logic [7:0] SEG_OFF  = 8'hFF;
  localparam logic [3:0] AN_OFF   = 4'b1111;

  typedef enum logic [1:0] {
    DIG_ONES     = 2'd0,
    DIG_TENS     = 2'd1,
    DIG_HUNDREDS = 2'd2,
    DIG_OVF      = 2'd3
  } digit_t;

  typedef struct packed {
    logic        ovf;
    logic [11:0] bcd;
  } shadow_t;

  function automatic logic [3:0] an_onehot(input digit_t d);
    return ~(4'b0001 << d);
  endfunction

endpackage

// File: rtl/bcd_to_sseg.sv
// BCD nibble to active-low seven-segment pattern; A-F show a dash.
// Ports: nibble (4b in), seg (7b out, {g,f,e,d,c,b,a}).
module bcd_to_sseg
  import bcd_disp_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_DASH;
    unique case (nibble)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/bcd_disp_mux.sv
// Four-digit multiplexed seven-segment driver for a 3-digit BCD value
// plus overflow "1". Ports: clk, reset_n (async low), bcd[11:0], ovf, en,
// an[3:0], sseg[7:0]. Macro BCD_DISP_LZB_EN enables leading-zero blanking.
module bcd_disp_mux
  import bcd_disp_pkg::*;
#(
  parameter int N = 18
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [11:0] bcd,
  input  logic        ovf,
  input  logic        en,
  output logic [3:0]  an,
  output logic [7:0]  sseg
);

  logic [N-1:0] q;
  shadow_t      sh;
  digit_t       sel;
  logic [3:0]   nib;
  logic [6:0]   seg;
  logic         blank_h;
  logic         blank_t;
  logic [3:0]   an_d;
  logic [7:0]   sseg_d;

  assign sel = digit_t'(q[N-1:N-2]);

  always_comb begin
    nib = sh.bcd[3:0];
    unique case (sel)
      DIG_ONES:     nib = sh.bcd[3:0];
      DIG_TENS:     nib = sh.bcd[7:4];
      DIG_HUNDREDS: nib = sh.bcd[11:8];
      DIG_OVF:      nib = sh.bcd[3:0];
    endcase
  end

  bcd_to_sseg u_dec (
    .nibble (nib),
    .seg    (seg)
  );

`ifdef BCD_DISP_LZB_EN
  // An overflowed value is 1xxx, so none of its digits are leading.
  assign blank_h = !sh.ovf && (sh.bcd[11:8] == 4'd0);
  assign blank_t = blank_h && (sh.bcd[7:4] == 4'd0);
`else
  assign blank_h = 1'b0;
  assign blank_t = 1'b0;
`endif

  always_comb begin
    an_d   = AN_OFF;
    sseg_d = SEG_OFF;
    unique case (sel)
      DIG_ONES: begin
        an_d   = an_onehot(sel);
        sseg_d = {1'b1, seg};
      end
      DIG_TENS: begin
        if (!blank_t) begin
          an_d   = an_onehot(sel);
          sseg_d = {1'b1, seg};
        end
      end
      DIG_HUNDREDS: begin
        if (!blank_h) begin
          an_d   = an_onehot(sel);
          sseg_d = {1'b1, seg};
        end
      end
      DIG_OVF: begin
        if (sh.ovf) begin
          an_d   = an_onehot(sel);
          sseg_d = {1'b1, SEG_1};
        end
      end
    endcase
    // Disable gates anodes only; segments keep decoding.
    if (!en) an_d = AN_OFF;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      q    <= '0;
      sh   <= '0;
      an   <= AN_OFF;
      sseg <= SEG_OFF;
    end else begin
      q    <= q + 1'b1;
      an   <= an_d;
      sseg <= sseg_d;
      // Capture on the last cycle of the frame so a frame never tears.
      if (q == {N{1'b1}}) begin
        sh.ovf <= ovf;
        sh.bcd <= bcd;
      end
    end
  end

endmodule
